// File: rtl/dsram_responder_if.sv
// ---------------------------------------------------------------------------
// dsram_responder_if
//   Bundles the core's dsram initiator port into a single interface.
//
//   Handshake: there is no valid/ready pair. dsram_e marks a request, and the
//   responder accepts every request in the cycle it is presented. Read data
//   appears on dsram_rdata one rising edge after the read, and it then holds
//   until the next read or reset.
//
//   Signals
//     dsram_e      access request this cycle
//     dsram_we     1 = write, 0 = read (qualified by dsram_e)
//     dsram_addr   byte address; bits [2:0] are ignored
//     dsram_wdata  write data, lane i = bits [8i+7:8i]
//     dsram_sel    byte-lane write enables
//     dsram_rdata  read data, full doubleword
//   Modports: master (core side), slave (responder side).
// ---------------------------------------------------------------------------
interface dsram_responder_if;
  logic        dsram_e;
  logic        dsram_we;
  logic [63:0] dsram_addr;
  logic [63:0] dsram_wdata;
  logic [7:0]  dsram_sel;
  logic [63:0] dsram_rdata;

  modport master (
    output dsram_e, dsram_we, dsram_addr, dsram_wdata, dsram_sel,
    input  dsram_rdata
  );

  modport slave (
    input  dsram_e, dsram_we, dsram_addr, dsram_wdata, dsram_sel,
    output dsram_rdata
  );
endinterface

// File: rtl/dsram_responder.sv
// ---------------------------------------------------------------------------
// dsram_responder
//   Data-side memory responder. It backs the core's dsram port with a
//   doubleword array of 2^ADDR_W x 64 bits. Writes are posted through a
//   one-entry write buffer. Reads merge in any buffered lanes, so they always
//   see the latest data. An access outside the window raises a one-cycle
//   fault pulse and bumps a saturating counter.
//
//   Ports
//     clk           single clock; all state changes on the rising edge
//     rst           asynchronous, active-low reset
//     bus           dsram_responder_if.slave (request in, read data out)
//     access_fault  one-cycle pulse following an out-of-window access
//     fault_count   saturating count of out-of-window accesses
// ---------------------------------------------------------------------------
module dsram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  dsram_responder_if.slave    bus,
  output logic                access_fault,
  output logic [15:0]         fault_count
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [63:0] WIN_BYTES = 64'd1 << (ADDR_W + 3);

  // Array contents are deliberately left out of reset.
  logic [63:0]       r_mem [DEPTH];

  logic              r_buf_valid;
  logic [ADDR_W-1:0] r_buf_idx;
  logic [63:0]       r_buf_data;
  logic [7:0]        r_buf_sel;

  logic [63:0]       r_rdata;
  logic              r_fault;
  logic [15:0]       r_fault_count;

  logic [63:0]       w_off;
  logic              w_in_win;
  logic [ADDR_W-1:0] w_idx;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_fault;
  logic              w_same_idx;
  logic              w_commit;
  logic [63:0]       w_rd_word;
  logic [63:0]       w_commit_word;
  logic [63:0]       w_buf_data_nx;
  logic [7:0]        w_buf_sel_nx;

  // The window check uses the offset from the base. The upper bound then
  // needs no BASE_ADDR + size term, which could wrap near the top of the
  // address space.
  assign w_off    = bus.dsram_addr - BASE_ADDR;
  assign w_in_win = (bus.dsram_addr >= BASE_ADDR) && (w_off < WIN_BYTES);
  assign w_idx    = w_off[ADDR_W+2:3];

  assign w_rd_acc = bus.dsram_e && !bus.dsram_we && w_in_win;
  assign w_wr_acc = bus.dsram_e && bus.dsram_we && w_in_win && (|bus.dsram_sel);

  // A write with no lanes selected is a no-op, even outside the window.
  assign w_fault  = bus.dsram_e && !w_in_win && (!bus.dsram_we || (|bus.dsram_sel));

  assign w_same_idx = r_buf_valid && (r_buf_idx == w_idx);

  // The buffer drains on every edge except one that merges a new write
  // into the same doubleword.
  assign w_commit = r_buf_valid && !(w_wr_acc && w_same_idx);

  always_comb begin
    w_rd_word     = r_mem[w_idx];
    w_commit_word = r_mem[r_buf_idx];
    w_buf_data_nx = w_same_idx ? r_buf_data : bus.dsram_wdata;
    w_buf_sel_nx  = w_same_idx ? (r_buf_sel | bus.dsram_sel) : bus.dsram_sel;
    for (int i = 0; i < 8; i++) begin
      if (w_same_idx && r_buf_sel[i]) begin
        w_rd_word[8*i +: 8] = r_buf_data[8*i +: 8];
      end
      if (r_buf_sel[i]) begin
        w_commit_word[8*i +: 8] = r_buf_data[8*i +: 8];
      end
      if (bus.dsram_sel[i]) begin
        w_buf_data_nx[8*i +: 8] = bus.dsram_wdata[8*i +: 8];
      end
    end
  end

  // The commit writes a whole doubleword that was merged from pre-edge
  // state, so a read on the same edge still sees the old array word plus
  // the buffer.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_buf_idx] <= w_commit_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_valid <= 1'b0;
      r_buf_idx   <= '0;
      r_buf_data  <= '0;
      r_buf_sel   <= '0;
    end else if (w_wr_acc) begin
      r_buf_valid <= 1'b1;
      r_buf_idx   <= w_idx;
      r_buf_data  <= w_buf_data_nx;
      r_buf_sel   <= w_buf_sel_nx;
    end else begin
      r_buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata       <= '0;
      r_fault       <= 1'b0;
      r_fault_count <= '0;
    end else begin
      r_fault <= w_fault;
      if (w_rd_acc) begin
        r_rdata <= w_rd_word;
      end else if (bus.dsram_e && !bus.dsram_we && !w_in_win) begin
        r_rdata <= '0;
      end
      if (w_fault && (r_fault_count != 16'hFFFF)) begin
        r_fault_count <= r_fault_count + 16'd1;
      end
    end
  end

  assign bus.dsram_rdata = r_rdata;
  assign access_fault    = r_fault;
  assign fault_count     = r_fault_count;

endmodule

// File: tb/tb_dsram_responder.sv
// ---------------------------------------------------------------------------
// tb_dsram_responder
//   Drives directed and random traffic into dsram_responder. For every clock
//   edge it queues the expected outputs, taken from an architectural memory
//   model. A monitor compares those against the DUT just after each edge.
// ---------------------------------------------------------------------------
module tb_dsram_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WIN  = 64'd32768;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsram_responder_if bus();
  logic        access_fault;
  logic [15:0] fault_count;

  dsram_responder #(.ADDR_W(12), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .bus          (bus),
    .access_fault (access_fault),
    .fault_count  (fault_count)
  );

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [80:0] exp_q[$];   // {rdata, fault, count} per edge

  // reference model: architectural memory contents
  logic [63:0] mdl_mem [longint unsigned];
  logic [63:0] mdl_rdata = '0;
  logic [15:0] mdl_cnt = '0;
  logic        pend_v = 1'b0;     // last edge accepted a write still buffered
  longint unsigned pend_idx = 0;
  logic [63:0] pend_orig = '0;    // word value before that write run

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: outputs update on every edge, so compare once per edge
  always @(posedge clk) begin
    logic [80:0] ent;
    #1;
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      check("rdata", bus.dsram_rdata, ent[80:17]);
      check("access_fault", {63'd0, access_fault}, {63'd0, ent[16]});
      check("fault_count", {48'd0, fault_count}, {48'd0, ent[15:0]});
    end
  end

  // driver: present one request, model it, advance one cycle
  task automatic cyc(input logic e, input logic we, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [7:0] sel);
    logic inwin;
    logic f;
    logic wr_ok;
    longint unsigned widx;
    logic [63:0] w;
    bus.dsram_e     = e;
    bus.dsram_we    = we;
    bus.dsram_addr  = addr;
    bus.dsram_wdata = wdata;
    bus.dsram_sel   = sel;
    inwin = (addr >= BASE) && ((addr - BASE) < WIN);
    widx  = longint'((addr - BASE) >> 3);
    f     = 1'b0;
    wr_ok = 1'b0;
    if (e) begin
      if (!inwin) begin
        if (!we || sel != 8'd0) begin
          f = 1'b1;
          if (!we) mdl_rdata = '0;
          if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
        end
      end else if (!we) begin
        mdl_rdata = mdl_mem[widx];
      end else if (sel != 8'd0) begin
        if (!(pend_v && pend_idx == widx)) begin
          pend_idx  = widx;
          pend_orig = mdl_mem[widx];
        end
        w = mdl_mem[widx];
        for (int i = 0; i < 8; i++)
          if (sel[i]) w[8*i +: 8] = wdata[8*i +: 8];
        mdl_mem[widx] = w;
        wr_ok = 1'b1;
      end
    end
    pend_v = wr_ok;
    exp_q.push_back({mdl_rdata, f, mdl_cnt});
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [63:0] addr);
    cyc(1'b1, 1'b0, addr, '0, '0);
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] sel);
    cyc(1'b1, 1'b1, addr, data, sel);
  endtask

  // reset asserted mid-cycle; a write buffered by the last edge is lost
  task automatic do_reset(input int n);
    bus.dsram_e = 1'b0;
    rst_n = 1'b0;
    if (pend_v) mdl_mem[pend_idx] = pend_orig;
    pend_v = 1'b0;
    mdl_rdata = '0;
    mdl_cnt = '0;
    #1;
    check("rst_rdata", bus.dsram_rdata, 64'd0);
    check("rst_fault", {63'd0, access_fault}, 64'd0);
    check("rst_count", {48'd0, fault_count}, 64'd0);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(81'd0);
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] rnd_addr();
    int k;
    logic [63:0] oow [4];
    oow[0] = 64'h0000_0000_7FFF_FFF8;
    oow[1] = 64'h0000_0000_8000_8000;
    oow[2] = 64'h0;
    oow[3] = 64'hFFFF_FFFF_FFFF_FFF8;
    if ($urandom_range(0, 3) != 0) begin
      k = $urandom_range(0, 8);
      return BASE + ((k == 8) ? 64'h7FF8 : 64'(k * 8)) + 64'($urandom_range(0, 7));
    end
    return oow[$urandom_range(0, 3)];
  endfunction

  initial begin
    bus.dsram_e = 1'b0;
    bus.dsram_we = 1'b0;
    bus.dsram_addr = '0;
    bus.dsram_wdata = '0;
    bus.dsram_sel = '0;
    do_reset(3);

    // known contents for every word the bench reads
    for (int k = 0; k < 8; k++) wr(BASE + 64'(k * 8), rnd64(), 8'hFF);
    wr(BASE + 64'h7FF8, rnd64(), 8'hFF);
    idle(1);

    // write then immediate read: forwarded from the buffer
    wr(64'h8000_0000, 64'h1122334455667788, 8'hFF);
    rd(64'h8000_0000);
    idle(1);

    // partial write committed after idle cycles
    wr(64'h8000_0000, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    idle(2);
    rd(64'h8000_0003);
    idle(1);

    // back-to-back same-word writes merge, then read before and after drain
    wr(64'h8000_0010, 64'h00000000000000EE, 8'h01);
    wr(64'h8000_0010, 64'hDD00000000000000, 8'h80);
    rd(64'h8000_0010);
    idle(3);
    rd(64'h8000_0010);
    idle(1);

    // window edges: below, last word, just past the end
    rd(64'h7FFF_FFF8);
    rd(64'h8000_8000);
    idle(1);
    rd(64'h8000_7FF8);
    wr(64'h8000_8000, 64'h1234, 8'hFF);
    wr(64'h7FFF_FFF8, 64'h1234, 8'h00);
    idle(2);

    // write buffered, reset before drain -> write lost
    wr(64'h8000_0020, 64'h000000000000CAFE, 8'hFF);
    do_reset(2);
    rd(64'h8000_0020);
    idle(1);

    // different-index write commits the previous buffer on the same edge
    wr(64'h8000_0028, rnd64(), 8'h3C);
    wr(64'h8000_0030, rnd64(), 8'hC3);
    rd(64'h8000_0028);
    rd(64'h8000_0030);

    // read data holds while idle
    rd(64'h8000_0008);
    idle(5);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: idle(1);
        1: rd(rnd_addr());
        default: wr(rnd_addr(), rnd64(), 8'($urandom_range(0, 255)));
      endcase
    end
    idle(3);
    for (int k = 0; k < 8; k++) rd(BASE + 64'(k * 8));
    idle(2);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsram_responder.md
Name: dsram_responder

Overview:
- Data-side memory responder: the far end of the core's dsram initiator port (dsram_e/we/addr/wdata/sel, returning dsram_rdata).
- Backs the port with a doubleword-organised synchronous array.
- Writes are posted through a one-entry write buffer; reads forward from that buffer.
- Flags out-of-window accesses for the simulation top and debug.

Parameters:
- ADDR_W, 12, doubleword index bits; array holds 2^ADDR_W x 64-bit words (32 KiB at default).
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0; window is [BASE_ADDR, BASE_ADDR + 2^(ADDR_W+3)).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- dsram_e  input  1  access request this cycle
- dsram_we  input  1  1 = write, 0 = read (qualified by dsram_e)
- dsram_addr  input  64  byte address; bits [2:0] ignored
- dsram_wdata  input  64  write data, lane i = bits [8i+7:8i]
- dsram_sel  input  8  byte-lane write enables, bit i -> lane i
- dsram_rdata  output  64  read data, full doubleword; the core extracts bytes
- access_fault  output  1  one-cycle pulse for an out-of-window access
- fault_count  output  16  saturating count of faults

Behaviour:
- Index = dsram_addr[ADDR_W+2:3] - BASE index.
  - In-window iff BASE_ADDR <= addr < BASE_ADDR + 2^(ADDR_W+3).
  - Compare on the full 64 bits; no wrap-around.
- Reset (rst=0, asynchronous):
  - dsram_rdata=0, access_fault=0, fault_count=0, buffer valid=0.
  - Array contents are not reset.
  - A buffered write pending at reset is discarded.
- Write buffer state: valid, idx[ADDR_W-1:0], data[63:0], sel[7:0].
- Read (e=1, we=0, in-window):
  - dsram_rdata is updated at the next rising edge (1-cycle latency).
  - Value returned = array[idx] with lane i replaced by buf.data lane i wherever buf.valid && buf.idx==idx && buf.sel[i].
  - The merge uses pre-edge state, so a commit on the same edge does not change the result.
- Write (e=1, we=1, in-window, sel!=0):
  - Buffer empty: load buffer with idx, wdata, sel; valid=1.
  - Buffer valid, same idx: merge in place — lanes with sel set take the new wdata, buf.sel |= sel; no commit.
  - Buffer valid, different idx: commit the old buffer to the array (sel lanes only) and load the new write, on the same edge.
- Write with sel==0: no state change, no fault.
- Any edge with no accepted write (idle, read, fault): a valid buffer commits and valid clears.
  - The buffer therefore never holds data for more than one cycle beyond the last write.
- dsram_e=0: dsram_rdata holds its previous value; no fault.
- Out-of-window access (read or write):
  - No array or buffer update from this access; a valid buffer still drains.
  - Read: dsram_rdata <= 0.
  - access_fault=1 for exactly the following cycle.
  - fault_count increments, saturating at 16'hFFFF.
- access_fault is 0 on every cycle not following a fault.
- No backpressure: every request is accepted in the cycle presented; throughput is one access per cycle.

Test Plan:
- Write 0x8000_0000 / 0x1122334455667788 / sel 0xFF, then read the same address next cycle -> dsram_rdata = 0x1122334455667788 one cycle after the read (buffer forward).
- Word holds 0x1122334455667788; write sel 0x0F, data 0xAAAAAAAABBBBBBBB; idle 2 cycles; read -> 0x11223344BBBBBBBB (committed partial write).
- Back-to-back writes to 0x8000_0010: sel 0x01 data 0x..EE, then sel 0x80 data 0xDD..; immediate read -> lane0=0xEE, lane7=0xDD, other lanes = prior contents; same value after 3 idle cycles.
- Read 0x7FFF_FFF8, then read 0x8000_8000 (ADDR_W=12) -> dsram_rdata=0 each; access_fault pulses on both following cycles; fault_count=2. Preload count near 0xFFFF -> it saturates at 0xFFFF.
- Write 0x8000_0020 = 0xCAFE, assert rst the next cycle before any idle, release, read 0x8000_0020 -> previous array contents (the buffered write is lost); all outputs 0 during reset.
- Read returns X, then dsram_e=0 for 5 cycles -> dsram_rdata stays X, access_fault stays 0.
